data_ram_ctrl: RTL and testbench

DATA_RAM_CTRL -- requirements
Module: data_ram_ctrl

---
 rtl/data_ram_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_data_ram_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// data_ram_ctrl
//
// Purpose:
//   Single-port 32-bit data RAM with a byte/half/word load-store front end.
//   After reset an optional clear sequencer zero-fills the whole array, one
//   word per cycle, before requests are accepted. Requests are accepted one
//   per cycle with no bubbles and answered by a one-cycle rsp_valid pulse on
//   the following cycle. Misaligned or reserved-size requests are answered
//   with rsp_err and have no side effects.
//
// Ports:
//   clk         in   single clock, rising edge
//   clr         in   synchronous active-high reset
//   sel         in   request valid
//   str         in   1 = store, 0 = load
//   Mode        in   [1:0] access size: 00 byte, 01 half, 10 word, 11 reserved
//   sign_ext    in   loads: 1 = sign-extend, 0 = zero-extend
//   Addr        in   [ADDR_WIDTH-1:0] byte address
//   Data_input  in   [31:0] store data, right-aligned
//   ready       out  request accepted on a cycle with sel && ready
//   rsp_valid   out  one-cycle response pulse for the previous accept
//   rsp_err     out  qualifies rsp_valid: misaligned or reserved size
//   Data_output out  [31:0] registered load result, right-aligned, extended
//   busy        out  clear sequencer is running
// ---------------------------------------------------------------------------
module data_ram_ctrl #(
  parameter int ADDR_WIDTH     = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  sel,
  input  logic                  str,
  input  logic [1:0]            Mode,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           Data_input,
  output logic                  ready,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           Data_output,
  output logic                  busy
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IDX_W;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] clear_idx;
  logic             clear_we;

  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] req_idx;
  logic [1:0]       req_lane;
  logic             req_err;
  logic             accept;
  logic             do_write;
  logic [3:0]       byte_en;
  logic [31:0]      wr_data;
  logic [31:0]      rd_word;
  logic [31:0]      load_data;

  // State register and clear index. Reset always lands in ST_CLEAR; when the
  // clear sequencer is disabled that state simply acts as the one-cycle
  // "pending" step that falls into ST_IDLE on the first edge with clr low.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_CLEAR;
      clear_idx <= '0;
    end else begin
      state <= next_state;
      if (clear_we) begin
        clear_idx <= clear_idx + 1'b1;
      end
    end
  end

  // Next-state and handshake outputs. The clear write is gated with clr so
  // that a reset landing mid-clear never touches memory by itself.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    busy       = 1'b0;
    clear_we   = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET) begin
          busy     = 1'b1;
          clear_we = !clr;
          if (clear_idx == '1) begin
            next_state = ST_IDLE;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_IDLE: begin
        ready = 1'b1;
      end
      default: begin
        next_state = ST_CLEAR;
      end
    endcase
  end

  // Request decode: word index, lane, alignment check and the byte enables
  // and lane-replicated write data used for partial-word stores.
  always_comb begin
    req_idx  = Addr[ADDR_WIDTH-1:2];
    req_lane = Addr[1:0];
    req_err  = 1'b0;
    byte_en  = 4'b0000;
    wr_data  = Data_input;
    unique case (Mode)
      SIZE_BYTE: begin
        byte_en = 4'b0001 << req_lane;
        wr_data = {4{Data_input[7:0]}};
      end
      SIZE_HALF: begin
        req_err = Addr[0];
        byte_en = Addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{Data_input[15:0]}};
      end
      SIZE_WORD: begin
        req_err = (Addr[1:0] != 2'b00);
        byte_en = 4'b1111;
        wr_data = Data_input;
      end
      default: begin
        req_err = 1'b1;
      end
    endcase
    accept   = sel && ready && !clr;
    do_write = accept && str && !req_err;
  end

  // Load formatting: pick the addressed byte/half out of the stored word,
  // move it to bit 0 and extend. Word loads pass straight through.
  always_comb begin
    rd_word   = mem[req_idx];
    load_data = rd_word;
    unique case (Mode)
      SIZE_BYTE: begin
        load_data[7:0] = rd_word[8*req_lane +: 8];
        load_data[31:8] = {24{sign_ext && rd_word[8*req_lane + 7]}};
      end
      SIZE_HALF: begin
        load_data[15:0] = Addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_data[31:16] = {16{sign_ext && (Addr[1] ? rd_word[31] : rd_word[15])}};
      end
      default: begin
        load_data = rd_word;
      end
    endcase
  end

  // Memory array. No reset here on purpose: only the clear sequencer is
  // allowed to zero the contents. Clear writes and store writes are
  // mutually exclusive because they belong to different FSM states.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clear_idx] <= 32'h0;
    end else if (do_write) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (byte_en[lane]) begin
          mem[req_idx][8*lane +: 8] <= wr_data[8*lane +: 8];
        end
      end
    end
  end

  // Response path. The pulse follows every accept; Data_output only moves
  // on a successful load so stores and errors leave it holding.
  always_ff @(posedge clk) begin
    if (clr) begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      Data_output <= 32'h0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && req_err;
      if (accept && !str && !req_err) begin
        Data_output <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_data_ram_ctrl
//
// Purpose:
//   Self-checking bench for data_ram_ctrl with ADDR_WIDTH=6 (16 words).
//   A behavioural model (word array plus last load result) predicts every
//   response; directed scenarios cover the documented cases and a random
//   run exercises mixed loads/stores with idle gaps.
// ---------------------------------------------------------------------------
module tb_data_ram_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        sel;
  logic        str;
  logic [1:0]  mode;
  logic        sign_ext;
  logic [5:0]  addr;
  logic [31:0] din;
  logic        ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] dout;
  logic        busy;

  int          passed = 0;
  int          total = 0;

  logic [31:0] ref_mem [16];
  logic [31:0] ref_dout;

  data_ram_ctrl #(
    .ADDR_WIDTH(6),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .clr(clr),
    .sel(sel),
    .str(str),
    .Mode(mode),
    .sign_ext(sign_ext),
    .Addr(addr),
    .Data_input(din),
    .ready(ready),
    .rsp_valid(rsp_valid),
    .rsp_err(rsp_err),
    .Data_output(dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference rules: alignment, load extraction and store merge expressed
  // as plain arithmetic on whole words.
  function automatic bit ref_err(input logic [1:0] m, input int a);
    return (m == 2'd3) || (m == 2'd1 && (a % 2) != 0) || (m == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] m,
                                           input bit s, input int a);
    logic [31:0] v;
    int sh;
    sh = (a % 4) * 8;
    if (m == 2'd2) return w;
    if (m == 2'd0) begin
      v = (w >> sh) & 32'hFF;
      if (s && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else begin
      v = (w >> sh) & 32'hFFFF;
      if (s && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] m, input int a, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    sh = (a % 4) * 8;
    mask = (m == 2'd0) ? 32'hFF : (m == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    ref_mem[a / 4] = (ref_mem[a / 4] & ~(mask << sh)) | ((d & mask) << sh);
  endtask

  // Drive one request for one accepted edge, then advance the model.
  task automatic do_req(input bit st, input logic [1:0] m, input bit s, input int a,
                        input logic [31:0] d, output bit e);
    sel = 1'b1;
    str = st;
    mode = m;
    sign_ext = s;
    addr = a[5:0];
    din = d;
    @(posedge clk);
    #1;
    sel = 1'b0;
    e = ref_err(m, a);
    if (!e) begin
      if (st) ref_store(m, a, d);
      else ref_dout = ref_load(ref_mem[a / 4], m, s, a);
    end
  endtask

  // Count cycles the clear sequencer is busy, bounded.
  task automatic wait_clear(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic test_reset();
    int n;
    bit e;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ref_dout = 32'h0;
    total++;
    if (busy !== 1'b1 || ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || dout !== 32'h0) begin
      $display("[TB] FAIL reset_state: busy=%b ready=%b valid=%b err=%b dout=%h, expected 1 0 0 0 00000000",
               busy, ready, rsp_valid, rsp_err, dout);
    end else passed++;
    clr = 1'b0;
    wait_clear(n);
    total++;
    if (n !== 16 || ready !== 1'b1) begin
      $display("[TB] FAIL reset_clear_len: busy cycles=%0d ready=%b, expected 16 and 1", n, ready);
    end else passed++;
    do_req(1'b0, 2'd2, 1'b0, 'h3C, 32'h0, e);
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || dout !== 32'h0) begin
      $display("[TB] FAIL reset_load_3c: valid=%b err=%b dout=%h, expected 1 0 00000000", rsp_valid, rsp_err, dout);
    end else passed++;
  endtask

  task automatic test_byte_lanes();
    bit e;
    do_req(1'b1, 2'd2, 1'b0, 'h08, 32'h11223344, e);
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || dout !== ref_dout) begin
      $display("[TB] FAIL lanes_store_rsp: valid=%b err=%b dout=%h, expected 1 0 %h", rsp_valid, rsp_err, dout, ref_dout);
    end else passed++;
    do_req(1'b1, 2'd0, 1'b0, 'h0A, 32'h000000AB, e);
    do_req(1'b0, 2'd2, 1'b0, 'h08, 32'h0, e);
    total++;
    if (dout !== 32'h11AB3344) begin
      $display("[TB] FAIL lanes_load: dout=%h, expected 11ab3344", dout);
    end else passed++;
  endtask

  task automatic test_extension();
    bit e;
    do_req(1'b1, 2'd2, 1'b0, 'h04, 32'h80FF7F01, e);
    do_req(1'b0, 2'd0, 1'b1, 'h06, 32'h0, e);
    total++;
    if (dout !== 32'hFFFFFFFF) $display("[TB] FAIL ext_byte_sx: dout=%h, expected ffffffff", dout);
    else passed++;
    do_req(1'b0, 2'd1, 1'b0, 'h06, 32'h0, e);
    total++;
    if (dout !== 32'h000080FF) $display("[TB] FAIL ext_half_zx: dout=%h, expected 000080ff", dout);
    else passed++;
    do_req(1'b0, 2'd0, 1'b1, 'h05, 32'h0, e);
    total++;
    if (dout !== 32'h0000007F) $display("[TB] FAIL ext_byte_pos: dout=%h, expected 0000007f", dout);
    else passed++;
    do_req(1'b0, 2'd1, 1'b1, 'h06, 32'h0, e);
    total++;
    if (dout !== 32'hFFFF80FF) $display("[TB] FAIL ext_half_sx: dout=%h, expected ffff80ff", dout);
    else passed++;
  endtask

  task automatic test_misalign();
    bit e;
    do_req(1'b1, 2'd2, 1'b0, 'h18, 32'h12345678, e);
    do_req(1'b0, 2'd2, 1'b0, 'h18, 32'h0, e);
    total++;
    if (dout !== 32'h12345678) $display("[TB] FAIL mis_setup: dout=%h, expected 12345678", dout);
    else passed++;
    do_req(1'b0, 2'd2, 1'b0, 'h02, 32'h0, e);
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || dout !== 32'h12345678) begin
      $display("[TB] FAIL mis_load_word: valid=%b err=%b dout=%h, expected 1 1 12345678", rsp_valid, rsp_err, dout);
    end else passed++;
    do_req(1'b1, 2'd1, 1'b0, 'h01, 32'h0000BEEF, e);
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
      $display("[TB] FAIL mis_store_half: valid=%b err=%b, expected 1 1", rsp_valid, rsp_err);
    end else passed++;
    do_req(1'b0, 2'd3, 1'b0, 'h00, 32'h0, e);
    total++;
    if (rsp_err !== 1'b1 || dout !== 32'h12345678) begin
      $display("[TB] FAIL mis_reserved: err=%b dout=%h, expected 1 12345678", rsp_err, dout);
    end else passed++;
    do_req(1'b0, 2'd2, 1'b0, 'h00, 32'h0, e);
    total++;
    if (rsp_err !== 1'b0 || dout !== ref_mem[0]) begin
      $display("[TB] FAIL mis_mem_unchanged: err=%b dout=%h, expected 0 %h", rsp_err, dout, ref_mem[0]);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    bit e;
    do_req(1'b1, 2'd2, 1'b0, 'h10, 32'hDEADBEEF, e);
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) $display("[TB] FAIL b2b_first: valid=%b err=%b, expected 1 0", rsp_valid, rsp_err);
    else passed++;
    do_req(1'b0, 2'd2, 1'b0, 'h10, 32'h0, e);
    total++;
    if (rsp_valid !== 1'b1 || dout !== 32'hDEADBEEF) begin
      $display("[TB] FAIL b2b_second: valid=%b dout=%h, expected 1 deadbeef", rsp_valid, dout);
    end else passed++;
    @(posedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0) $display("[TB] FAIL b2b_pulse_end: valid=%b, expected 0", rsp_valid);
    else passed++;
  endtask

  task automatic test_random();
    bit e;
    bit go;
    int a;
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      go = ($urandom_range(0, 3) != 0);
      a = $urandom_range(0, 63);
      if (go) begin
        do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               a, $urandom, e);
      end else begin
        e = 1'b0;
        addr = a[5:0];
        str = 1'b1;
        @(posedge clk);
        #1;
      end
      total++;
      if (rsp_valid !== go || (go && rsp_err !== e) || dout !== ref_dout) begin
        if (bad < 10) $display("[TB] FAIL rand_%0d: valid=%b err=%b dout=%h, expected %b %b %h",
                               i, rsp_valid, rsp_err, dout, go, e, ref_dout);
        bad++;
      end else passed++;
    end
  endtask

  task automatic test_clear_restart();
    int n;
    bit e;
    bit stray;
    for (int i = 0; i < 16; i++) do_req(1'b1, 2'd2, 1'b0, i * 4, 32'hA5A50000 + i, e);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    stray = 1'b0;
    sel = 1'b1;
    str = 1'b1;
    mode = 2'd2;
    addr = 6'h3C;
    din = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b0 || ready !== 1'b0) stray = 1'b1;
    end
    total++;
    if (stray || busy !== 1'b1) $display("[TB] FAIL clear_ignore: stray=%b busy=%b, expected 0 1", stray, busy);
    else passed++;
    sel = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    wait_clear(n);
    total++;
    if (n !== 16) $display("[TB] FAIL clear_restart_len: busy cycles=%0d, expected 16", n);
    else passed++;
    ref_dout = 32'h0;
    do_req(1'b0, 2'd2, 1'b0, 'h3C, 32'h0, e);
    total++;
    if (dout !== 32'h0) $display("[TB] FAIL clear_restart_w15: dout=%h, expected 00000000", dout);
    else passed++;
    do_req(1'b0, 2'd2, 1'b0, 'h1C, 32'h0, e);
    total++;
    if (dout !== 32'h0) $display("[TB] FAIL clear_restart_w7: dout=%h, expected 00000000", dout);
    else passed++;
  endtask

  task automatic test_clr_collision();
    int n;
    bit e;
    sel = 1'b1;
    str = 1'b1;
    mode = 2'd2;
    sign_ext = 1'b0;
    addr = 6'h14;
    din = 32'hCAFEF00D;
    clr = 1'b1;
    @(posedge clk);
    #1;
    sel = 1'b0;
    clr = 1'b0;
    ref_dout = 32'h0;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL coll_no_rsp: valid=%b busy=%b, expected 0 1", rsp_valid, busy);
    else passed++;
    wait_clear(n);
    total++;
    if (n !== 16) $display("[TB] FAIL coll_clear_len: busy cycles=%0d, expected 16", n);
    else passed++;
    do_req(1'b0, 2'd2, 1'b0, 'h14, 32'h0, e);
    total++;
    if (rsp_valid !== 1'b1 || dout !== 32'h0) $display("[TB] FAIL coll_word: valid=%b dout=%h, expected 1 00000000", rsp_valid, dout);
    else passed++;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr = 1'b1;
    sel = 1'b0;
    str = 1'b0;
    mode = 2'd0;
    sign_ext = 1'b0;
    addr = 6'h0;
    din = 32'h0;
    ref_dout = 32'h0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    #1;
    test_reset();
    test_byte_lanes();
    test_extension();
    test_misalign();
    test_back_to_back();
    test_random();
    test_clear_restart();
    test_clr_collision();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
